// File: rtl/i2c_slave_port_if.sv
// Local-side strobe interface of the I2C target, plus FSM state and SDA drive
// exposed for observation.
interface i2c_slave_port_if;
    // Strobe semantics (no back-pressure; local logic must always accept):
    //  rx_valid pulses for exactly one clk in the cycle rx_data first shows a new byte;
    //  tx_load pulses for exactly one clk in the cycle the target samples tx_data.
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;
    logic [2:0] state_dbg;
    logic       sda_oe_dbg;

    modport slave (
        output rx_data, rx_valid, tx_load, busy, state_dbg, sda_oe_dbg,
        input  tx_data
    );

    modport master (
        input  rx_data, rx_valid, tx_load, busy, state_dbg, sda_oe_dbg,
        output tx_data
    );
endinterface

// File: rtl/i2c_slave_port.sv
// I2C target: oversampled SCL/SDA, START/STOP detect, 7-bit address match, one
// data byte per transfer. Optional glitch filter enabled by I2C_SLAVE_FILTER_EN.
module i2c_slave_port #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i2c_scl,
    inout  wire              i2c_sda,
    i2c_slave_port_if.slave  lp
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX        = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX        = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] line;
    logic [1:0] prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {i2c_scl, i2c_sda};
            sync_q <= meta_q;
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]     filt_q;
    logic [FCW-1:0] fcnt_q [2];

    // A line only follows its input once the new level has held FILTER_LEN clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign line = filt_q;
`else
    assign line = sync_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 2'b11;
        end else begin
            prev_q <= line;
        end
    end

    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_f     = line[1];
    assign sda_f     = line[0];
    assign scl_rise  = scl_f & ~prev_q[1];
    assign scl_fall  = ~scl_f & prev_q[1];
    assign start_det = scl_f & prev_q[1] & prev_q[0] & ~sda_f;
    assign stop_det  = scl_f & prev_q[1] & ~prev_q[0] & sda_f;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic [7:0] shift_in;

    assign shift_in = {shift_q[6:0], sda_f};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd7;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d  = S_ADDR;
            bitcnt_d = 3'd7;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end

                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bitcnt_q == 3'd0) begin
                            rw_d = shift_in[0];
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                state_d   = S_ADDR_ACK;
                                tx_load_d = shift_in[0];
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end

                // sda_oe_q doubles as the ACK phase: the first fall starts the
                // ACK, the second ends it and hands over to the data phase.
                S_ADDR_ACK: begin
                    if (tx_load_q) begin
                        shift_d = lp.tx_data;
                    end
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bitcnt_d = 3'd7;
                            if (rw_q) begin
                                state_d  = S_TX;
                                sda_oe_d = ~shift_q[7];
                            end else begin
                                state_d  = S_RX;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end

                S_RX: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bitcnt_q == 3'd0) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            state_d    = S_RX_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end

                S_RX_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_WAIT_STOP;
                        end
                    end
                end

                S_TX: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_TX_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                // Master ACK and NACK both end the single-byte read.
                S_TX_ACK: begin
                    if (scl_rise) begin
                        state_d = S_WAIT_STOP;
                    end
                end

                S_WAIT_STOP: begin
                end

                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign i2c_sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign lp.rx_data    = rx_data_q;
    assign lp.rx_valid   = rx_valid_q;
    assign lp.tx_load    = tx_load_q;
    assign lp.busy       = (state_q != S_IDLE);
    assign lp.state_dbg  = state_q;
    assign lp.sda_oe_dbg = sda_oe_q;

endmodule

// File: tb/tb_i2c_slave_port.sv
// Directed bench for i2c_slave_port: write, read, address mismatch, abort and
// repeated START, asynchronous reset mid-ACK, and SDA glitch handling.
module tb_i2c_slave_port;

    localparam int Q = 4;

`ifdef I2C_SLAVE_FILTER_EN
    localparam logic GLITCH_IS_START = 1'b0;
`else
    localparam logic GLITCH_IS_START = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    wire  sda_bus;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int txl_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    int b_rxv, b_txl, b_oe, b_busy;
    logic       bit_v;
    logic [7:0] byte_v;

    i2c_slave_port_if lp ();

    assign sda_bus = sda_m ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_slave_port #(
        .SLAVE_ADDR (7'h42),
        .FILTER_LEN (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i2c_scl (scl_m),
        .i2c_sda (sda_bus),
        .lp      (lp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lp.rx_valid)   rxv_cnt++;
        if (lp.tx_load)    txl_cnt++;
        if (lp.sda_oe_dbg) oe_cnt++;
        if (lp.busy)       busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        tick(Q);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(2 * Q);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        tick(2 * Q);
        scl_m = 1'b1;
        tick(Q);
        b = sda_bus;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        v = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    initial begin
        lp.tx_data = 8'h00;
        tick(3);
        check("reset_rx_data", {24'h0, lp.rx_data}, 32'h00);
        check("reset_rx_valid", {31'h0, lp.rx_valid}, 32'h0);
        check("reset_tx_load", {31'h0, lp.tx_load}, 32'h0);
        check("reset_busy", {31'h0, lp.busy}, 32'h0);
        check("reset_sda_oe", {31'h0, lp.sda_oe_dbg}, 32'h0);
        rst = 1'b1;
        tick(4);
        check("idle_state", {29'h0, lp.state_dbg}, 32'd0);

        // Write 0xA5 to 0x42
        b_rxv = rxv_cnt;
        i2c_start();
        tick(Q);
        check("wr_busy_after_start", {31'h0, lp.busy}, 32'h1);
        check("wr_state_addr", {29'h0, lp.state_dbg}, 32'd1);
        send_byte(8'h84);
        read_bit(bit_v);
        check("wr_addr_ack", {31'h0, bit_v}, 32'h0);
        send_byte(8'hA5);
        read_bit(bit_v);
        check("wr_data_ack", {31'h0, bit_v}, 32'h0);
        check("wr_rx_data", {24'h0, lp.rx_data}, 32'hA5);
        check("wr_rx_valid_pulses", rxv_cnt - b_rxv, 32'd1);
        i2c_stop();
        check("wr_busy_after_stop", {31'h0, lp.busy}, 32'h0);
        check("wr_sda_released", {31'h0, sda_bus}, 32'h1);

        // Read 0x3C from 0x42, master NACKs
        b_rxv = rxv_cnt;
        b_txl = txl_cnt;
        lp.tx_data = 8'h3C;
        i2c_start();
        send_byte(8'h85);
        read_bit(bit_v);
        check("rd_addr_ack", {31'h0, bit_v}, 32'h0);
        check("rd_tx_load_pulses", txl_cnt - b_txl, 32'd1);
        lp.tx_data = 8'hFF;
        read_byte(byte_v);
        check("rd_byte", {24'h0, byte_v}, 32'h3C);
        send_bit(1'b1);
        i2c_stop();
        check("rd_busy_after_stop", {31'h0, lp.busy}, 32'h0);
        check("rd_state_idle", {29'h0, lp.state_dbg}, 32'd0);
        check("rd_no_rx_valid", rxv_cnt - b_rxv, 32'd0);
        check("rd_tx_load_total", txl_cnt - b_txl, 32'd1);

        // Address mismatch: 0x43 write, target stays off the bus
        b_rxv = rxv_cnt;
        b_oe  = oe_cnt;
        i2c_start();
        send_byte(8'h86);
        read_bit(bit_v);
        check("mm_addr_nack", {31'h0, bit_v}, 32'h1);
        send_byte(8'hFF);
        read_bit(bit_v);
        check("mm_data_nack", {31'h0, bit_v}, 32'h1);
        i2c_stop();
        check("mm_never_driven", oe_cnt - b_oe, 32'd0);
        check("mm_no_rx_valid", rxv_cnt - b_rxv, 32'd0);
        check("mm_busy_after_stop", {31'h0, lp.busy}, 32'h0);

        // STOP after 4 data bits, then a repeated START aborting a partial byte
        b_rxv = rxv_cnt;
        i2c_start();
        send_byte(8'h84);
        read_bit(bit_v);
        check("ab_addr_ack", {31'h0, bit_v}, 32'h0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_stop();
        check("ab_state_idle", {29'h0, lp.state_dbg}, 32'd0);
        check("ab_sda_oe", {31'h0, lp.sda_oe_dbg}, 32'h0);
        check("ab_no_rx_valid", rxv_cnt - b_rxv, 32'd0);
        i2c_start();
        send_byte(8'h84);
        read_bit(bit_v);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_start();
        send_byte(8'h84);
        read_bit(bit_v);
        check("rs_addr_ack", {31'h0, bit_v}, 32'h0);
        send_byte(8'h5A);
        read_bit(bit_v);
        check("rs_data_ack", {31'h0, bit_v}, 32'h0);
        i2c_stop();
        check("rs_rx_data", {24'h0, lp.rx_data}, 32'h5A);
        check("rs_rx_valid_pulses", rxv_cnt - b_rxv, 32'd1);

        // Asynchronous reset while the target drives the address ACK
        i2c_start();
        send_byte(8'h84);
        sda_m = 1'b1;
        tick(2 * Q - 1);
        check("rst_ack_driven", {31'h0, lp.sda_oe_dbg}, 32'h1);
        check("rst_bus_low", {31'h0, sda_bus}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_sda_oe", {31'h0, lp.sda_oe_dbg}, 32'h0);
        check("rst_bus_released", {31'h0, sda_bus}, 32'h1);
        check("rst_busy", {31'h0, lp.busy}, 32'h0);
        check("rst_rx_data", {24'h0, lp.rx_data}, 32'h00);
        check("rst_state", {29'h0, lp.state_dbg}, 32'd0);
        check("rst_tx_load", {31'h0, lp.tx_load}, 32'h0);
        check("rst_rx_valid", {31'h0, lp.rx_valid}, 32'h0);
        scl_m = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(8);

        // One-clk SDA low glitch while SCL is high and the bus is idle
        b_busy = busy_cnt;
        sda_m = 1'b0;
        tick(1);
        sda_m = 1'b1;
        tick(12);
        check("glitch_busy_seen", {31'h0, (busy_cnt - b_busy) > 0}, {31'h0, GLITCH_IS_START});
        check("glitch_state_idle", {29'h0, lp.state_dbg}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
